hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single pipeline clock, rising-edge.
REQ-002 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-004 SHALL have ports Rs1E, Rs2E, RdE  in  5 each  execute-stage sources/destination.
REQ-005 SHALL have ports RegWriteE, LoadE, MulDivE, PCSrcE  in  1 each  E-stage write-enable, load, multi-cycle op, taken branch/jump.
REQ-006 SHALL have ports RdM, RegWriteM, RdW, RegWriteW  in  5/1/5/1  memory/writeback destination and write-enable.
REQ-007 SHALL have ports Forward_AE, Forward_BE  out  2 each  execute operand mux selects: 00 rs data, 01 writeback Result, 10 memory AddResult; 11 never driven.
REQ-008 SHALL have ports StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy  out  1 each  pipeline register controls; Busy = multi-cycle op in progress.

Function
REQ-009 Forward_AE SHALL be 10 when RegWriteM & RdM!=0 & RdM==Rs1E; else 01 when RegWriteW & RdW!=0 & RdW==Rs1E; else 00 (memory wins over writeback).
REQ-010 Forward_BE SHALL follow REQ-009 using Rs2E; both selects are combinational, zero-cycle latency, valid in every state including stalls.
REQ-011 FSM states SHALL be RUN, MD_BUSY, MD_DONE; 2-bit down-counter cnt.
REQ-012 RUN, MulDivE=1: StallF=StallD=StallE=BubbleM=Busy=1 that cycle, cnt<=MD_LAT-2, next MD_BUSY.
REQ-013 MD_BUSY: StallF/StallD/StallE/BubbleM/Busy=1; cnt decrements; when cnt==1 next state MD_DONE.
REQ-014 MD_DONE: no stall, Busy=0, MulDivE ignored (same op still in E), next RUN; multi-cycle op thus occupies E exactly MD_LAT=4 cycles.
REQ-015 RUN, load-use (LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)), no MulDivE: StallF=StallD=FlushE=1 for that cycle only; FSM stays RUN.
REQ-016 RUN, PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0; overrides simultaneous load-use.
REQ-017 PCSrcE and LoadE SHALL be ignored outside RUN; MulDivE with PCSrcE in RUN: MulDivE wins, branch ignored (cannot legally coincide).
REQ-018 Outputs not asserted by REQ-012..REQ-016 SHALL be 0; no output depends on state other than as listed.

Reset
REQ-019 rst_n low SHALL force state=RUN, cnt=0 immediately, regardless of clk, including mid multi-cycle op.
REQ-020 During reset all stall/flush/bubble/Busy outputs SHALL be 0; Forward_* remain purely combinational from inputs.
REQ-021 First rising clk after rst_n deasserts SHALL evaluate from RUN.

Structure
REQ-022 Shared package hazard_pkg SHALL hold state enum, MD_LAT=4, and FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-023 Forward selection SHALL be one sub-module forward_sel, instantiated twice (operand A, B).
REQ-024 FSM and counter SHALL live in hazard_ctrl; single always-block for registers, one for next-state/outputs.

Verification
REQ-025 Rs1E=5, RdM=5 RegWriteM=1, RdW=5 RegWriteW=1 -> Forward_AE=10; drop RegWriteM -> 01; RdM=RdW=0 -> 00.
REQ-026 LoadE=1 RdE=7, Rs2D=7 in RUN -> StallF=StallD=FlushE=1 one cycle, next cycle (LoadE=0) all 0.
REQ-027 MulDivE=1 held 4 cycles from RUN -> StallE/BubbleM/Busy=1 cycles 0-2, 0 in cycle 3, state RUN in cycle 4.
REQ-028 PCSrcE=1 with simultaneous load-use -> FlushD=FlushE=1, StallF=StallD=0.
REQ-029 rst_n pulsed low in MD_BUSY (cnt=1) -> all controls 0 asynchronously; after release MulDivE=0 -> stays RUN.
REQ-030 Random stimulus vs. reference model 10k cycles -> Forward_* never 11, Busy never exceeds 3 consecutive cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    localparam int         MD_LAT   = 4;
    localparam logic [1:0] CNT_LOAD = 2'(MD_LAT - 2);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired to zero, so it never creates a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - operand forwarding select for one execute-stage source
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    // The memory stage holds the younger result, so it takes priority
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && reg_match(rd_m_i, rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && reg_match(rd_w_i, rs_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use, branch flush and multi-cycle stall control
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic       LoadE,
    input  logic       MulDivE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] Forward_AE,
    output logic [1:0] Forward_BE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       BubbleM,
    output logic       Busy
);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, busy;
    logic load_use;
    logic unused_reg_write_e;

    assign unused_reg_write_e = RegWriteE;

    forward_sel u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (Forward_AE)
    );

    forward_sel u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (Forward_BE)
    );

    assign load_use = LoadE && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_m = 1'b0;
        busy     = 1'b0;

        unique case (state_q)
            RUN: begin
                // Priority: multi-cycle op, then taken branch, then load-use
                if (MulDivE) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    bubble_m = 1'b1;
                    busy     = 1'b1;
                    cnt_d    = CNT_LOAD;
                    state_d  = MD_BUSY;
                end else if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MD_BUSY: begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                bubble_m = 1'b1;
                busy     = 1'b1;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                // Result leaves E this cycle; the still-high MulDivE is the same op
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Controls are held low for the whole reset window, not just after the edge
    assign StallF  = rst_n & stall_f;
    assign StallD  = rst_n & stall_d;
    assign StallE  = rst_n & stall_e;
    assign FlushD  = rst_n & flush_d;
    assign FlushE  = rst_n & flush_e;
    assign BubbleM = rst_n & bubble_m;
    assign Busy    = rst_n & busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, LoadE, MulDivE, PCSrcE, RegWriteM, RegWriteW;
    logic [1:0] Forward_AE, Forward_BE;
    logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [6:0] C_NONE = 7'h00;
    localparam logic [6:0] C_LU   = 7'h64;
    localparam logic [6:0] C_BR   = 7'h0C;
    localparam logic [6:0] C_MD   = 7'h73;

    wire [6:0] ctrl = {StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .LoadE      (LoadE),
        .MulDivE    (MulDivE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .Forward_AE (Forward_AE),
        .Forward_BE (Forward_BE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .BubbleM    (BubbleM),
        .Busy       (Busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; LoadE = 0; MulDivE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    task automatic set_load_use();
        LoadE = 1; RdE = 7; Rs2D = 7; Rs1D = 3; RegWriteE = 1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic rwm, input logic [4:0] rdw, input logic rww);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    int         op_age;
    int         busy_run;
    logic [6:0] exp_c;
    logic       lu;

    initial begin
        idle_inputs();
        rst_n = 0;
        MulDivE = 1; Rs1E = 5; RdM = 5; RegWriteM = 1;
        #1;
        chk("reset_ctrl_zero", {1'b0, ctrl}, {1'b0, C_NONE});
        chk("reset_fwd_comb", {6'd0, Forward_AE}, 8'h02);

        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1;
        chk("fwdA_mem_wins", {6'd0, Forward_AE}, 8'h02);
        chk("ctrl_idle", {1'b0, ctrl}, {1'b0, C_NONE});
        RegWriteM = 0; #1;
        chk("fwdA_wb", {6'd0, Forward_AE}, 8'h01);
        RdM = 0; RdW = 0; RegWriteM = 1; #1;
        chk("fwdA_x0", {6'd0, Forward_AE}, 8'h00);
        Rs2E = 9; RdM = 9; RdW = 9; RegWriteM = 1; RegWriteW = 1; #1;
        chk("fwdB_mem", {6'd0, Forward_BE}, 8'h02);
        RdM = 3; #1;
        chk("fwdB_wb", {6'd0, Forward_BE}, 8'h01);
        RdM = 9; RegWriteM = 0; RdW = 4; #1;
        chk("fwdB_rf", {6'd0, Forward_BE}, 8'h00);

        @(negedge clk);
        idle_inputs(); set_load_use(); #1;
        chk("load_use", {1'b0, ctrl}, {1'b0, C_LU});
        @(negedge clk);
        LoadE = 0; #1;
        chk("load_use_release", {1'b0, ctrl}, {1'b0, C_NONE});
        LoadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
        chk("load_x0_no_stall", {1'b0, ctrl}, {1'b0, C_NONE});

        @(negedge clk);
        idle_inputs(); set_load_use(); PCSrcE = 1; #1;
        chk("branch_over_lu", {1'b0, ctrl}, {1'b0, C_BR});

        @(negedge clk);
        idle_inputs(); MulDivE = 1; PCSrcE = 1; #1;
        chk("md_c0_over_branch", {1'b0, ctrl}, {1'b0, C_MD});
        @(negedge clk);
        set_load_use(); #1;
        chk("md_c1_busy", {1'b0, ctrl}, {1'b0, C_MD});
        @(negedge clk);
        #1;
        chk("md_c2_busy", {1'b0, ctrl}, {1'b0, C_MD});
        @(negedge clk);
        #1;
        chk("md_c3_done", {1'b0, ctrl}, {1'b0, C_NONE});
        @(negedge clk);
        MulDivE = 0; PCSrcE = 0; #1;
        chk("md_c4_run", {1'b0, ctrl}, {1'b0, C_LU});

        @(negedge clk);
        idle_inputs(); MulDivE = 1; #1;
        chk("md2_c0", {1'b0, ctrl}, {1'b0, C_MD});
        @(negedge clk);
        #1;
        chk("md2_c1", {1'b0, ctrl}, {1'b0, C_MD});
        @(negedge clk);
        MulDivE = 0; #1;
        chk("md2_c2_cnt1", {1'b0, ctrl}, {1'b0, C_MD});
        rst_n = 0; #1;
        chk("async_reset_ctrl", {1'b0, ctrl}, {1'b0, C_NONE});
        rst_n = 1; #1;
        chk("post_reset_run", {1'b0, ctrl}, {1'b0, C_NONE});
        @(negedge clk);
        #1;
        chk("post_reset_idle", {1'b0, ctrl}, {1'b0, C_NONE});
        @(negedge clk);
        set_load_use(); #1;
        chk("post_reset_lu", {1'b0, ctrl}, {1'b0, C_LU});
        @(negedge clk);
        idle_inputs();

        op_age = 0;
        busy_run = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            RegWriteE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            LoadE   = 1'($urandom);
            PCSrcE  = ($urandom_range(0, 3) == 0);
            MulDivE = ($urandom_range(0, 7) == 0);
            #1;
            lu = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if (op_age != 0)  exp_c = (op_age < 3) ? C_MD : C_NONE;
            else if (MulDivE) exp_c = C_MD;
            else if (PCSrcE)  exp_c = C_BR;
            else if (lu)      exp_c = C_LU;
            else              exp_c = C_NONE;
            busy_run = Busy ? busy_run + 1 : 0;
            chk("rand_ctrl", {1'b0, ctrl}, {1'b0, exp_c});
            chk("rand_fwd", {4'd0, Forward_AE, Forward_BE},
                {4'd0, ref_fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW),
                       ref_fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW)});
            chk("rand_busy_run_le3", {7'd0, busy_run > 3}, 8'h00);
            if (op_age == 0 && MulDivE) op_age = 1;
            else if (op_age == 3)       op_age = 0;
            else if (op_age != 0)       op_age++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
